// File: rtl/ser4_tx_pkg.sv
// ser4_tx_pkg: shared definitions for the ser4_tx transmitter.
//   state_t      - FSM state encoding (ST_IDLE, ST_SHIFT)
//   first_sel()  - lane select that starts a nibble (0, or 3 when MSB first)
//   last_sel()   - lane select that ends a nibble (3, or 0 when MSB first)
//   cnt_width()  - prescaler width for a given DIV (clog2, at least 1 bit)
package ser4_tx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic logic [1:0] first_sel(input bit msb_first);
        return msb_first ? 2'd3 : 2'd0;
    endfunction

    function automatic logic [1:0] last_sel(input bit msb_first);
        return msb_first ? 2'd0 : 2'd3;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/ser4_tx_if.sv
// ser4_tx_if: nibble handshake into the transmitter.
//   din    - nibble to send, din[i] maps to lane si
//   dvalid - din is valid
//   dready - transmitter accepts din this cycle
// master = nibble source, slave = ser4_tx.
interface ser4_tx_if;
    logic [3:0] din;
    logic       dvalid;
    logic       dready;

    modport master (output din, output dvalid, input dready);
    modport slave  (input din, input dvalid, output dready);
endinterface

// File: rtl/ser4_tx_mux4.sv
// ser4_tx_mux4: 4:1 lane mux driving the serial bit.
//   sel        - lane select
//   d0..d3     - lane inputs
//   y          - selected lane
module ser4_tx_mux4 (
    input  logic [1:0] sel,
    input  logic       d0,
    input  logic       d1,
    input  logic       d2,
    input  logic       d3,
    output logic       y
);

    always_comb begin
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/ser4_tx.sv
// ser4_tx: 4-bit parallel-to-serial transmitter.
//   clk, rst   - rising-edge clock, synchronous active-high reset
//   bus        - nibble handshake (din/dvalid/dready), slave side
//   sel        - registered lane select, stepped once per bit period
//   s0..s3     - registered lanes holding the captured nibble
//   sout       - serial line (selected lane in SHIFT, IDLE_LVL otherwise)
//   busy       - high while in SHIFT
//   done       - one-cycle pulse on the final clock of the last bit
// Parameters: DIV clocks per bit (1..256), IDLE_LVL idle line level,
// MSB_FIRST selects lane order 3,2,1,0 instead of 0,1,2,3.
module ser4_tx
    import ser4_tx_pkg::*;
#(
    parameter int unsigned DIV       = 1,
    parameter bit          IDLE_LVL  = 1'b1,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    ser4_tx_if.slave       bus,
    output logic [1:0]     sel,
    output logic           s0,
    output logic           s1,
    output logic           s2,
    output logic           s3,
    output logic           sout,
    output logic           busy,
    output logic           done
);

    localparam int unsigned    CW      = cnt_width(DIV);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);
    localparam logic [1:0]     FIRST   = first_sel(MSB_FIRST);
    localparam logic [1:0]     LAST    = last_sel(MSB_FIRST);

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [1:0]    sel_d;
    logic [3:0]    lanes, lanes_d;
    logic          tick, last_tick, accept, lane_bit;

    // Handshake qualifiers: dready comes from state/counters only, so no
    // combinational path exists from dvalid back to dready.
    always_comb begin
        tick       = (state == ST_SHIFT) && (cnt == CNT_MAX);
        last_tick  = tick && (sel == LAST);
        bus.dready = (state == ST_IDLE) || last_tick;
        accept     = bus.dvalid && bus.dready;
    end

    // Next-state logic. A capture on the last tick restarts SHIFT directly,
    // giving back-to-back nibbles with no idle gap.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        sel_d   = sel;
        lanes_d = lanes;
        if (accept) begin
            state_d = ST_SHIFT;
            cnt_d   = '0;
            sel_d   = FIRST;
            lanes_d = bus.din;
        end else if (state == ST_SHIFT) begin
            if (tick) begin
                cnt_d = '0;
                sel_d = MSB_FIRST ? (sel - 2'd1) : (sel + 2'd1);
                if (last_tick) begin
                    state_d = ST_IDLE;
                end
            end else begin
                cnt_d = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            sel   <= FIRST;
            lanes <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            sel   <= sel_d;
            lanes <= lanes_d;
        end
    end

    ser4_tx_mux4 u_mux (
        .sel (sel),
        .d0  (lanes[0]),
        .d1  (lanes[1]),
        .d2  (lanes[2]),
        .d3  (lanes[3]),
        .y   (lane_bit)
    );

    always_comb begin
        {s3, s2, s1, s0} = lanes;
        busy             = (state == ST_SHIFT);
        done             = last_tick;
        sout             = busy ? lane_bit : IDLE_LVL;
    end

endmodule

// File: tb/tb_ser4_tx.sv
// tb_ser4_tx: directed self-checking bench for ser4_tx.
// Four instances cover the parameter sets used by the directed vectors:
//   a: DIV=1 LSB first idle 1    b: DIV=3 MSB first idle 1
//   c: DIV=2 LSB first idle 1    d: DIV=1 LSB first idle 0
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ser4_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c, rst_d;

    ser4_tx_if ifa ();
    ser4_tx_if ifb ();
    ser4_tx_if ifc ();
    ser4_tx_if ifd ();

    logic [1:0] sel_a, sel_b, sel_c, sel_d;
    logic [3:0] ln_a, ln_b, ln_c, ln_d;
    logic       sout_a, sout_b, sout_c, sout_d;
    logic       busy_a, busy_b, busy_c, busy_d;
    logic       done_a, done_b, done_c, done_d;

    ser4_tx #(.DIV(1), .IDLE_LVL(1'b1), .MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst(rst_a), .bus(ifa.slave), .sel(sel_a),
        .s0(ln_a[0]), .s1(ln_a[1]), .s2(ln_a[2]), .s3(ln_a[3]),
        .sout(sout_a), .busy(busy_a), .done(done_a)
    );

    ser4_tx #(.DIV(3), .IDLE_LVL(1'b1), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst(rst_b), .bus(ifb.slave), .sel(sel_b),
        .s0(ln_b[0]), .s1(ln_b[1]), .s2(ln_b[2]), .s3(ln_b[3]),
        .sout(sout_b), .busy(busy_b), .done(done_b)
    );

    ser4_tx #(.DIV(2), .IDLE_LVL(1'b1), .MSB_FIRST(1'b0)) dut_c (
        .clk(clk), .rst(rst_c), .bus(ifc.slave), .sel(sel_c),
        .s0(ln_c[0]), .s1(ln_c[1]), .s2(ln_c[2]), .s3(ln_c[3]),
        .sout(sout_c), .busy(busy_c), .done(done_c)
    );

    ser4_tx #(.DIV(1), .IDLE_LVL(1'b0), .MSB_FIRST(1'b0)) dut_d (
        .clk(clk), .rst(rst_d), .bus(ifd.slave), .sel(sel_d),
        .s0(ln_d[0]), .s1(ln_d[1]), .s2(ln_d[2]), .s3(ln_d[3]),
        .sout(sout_d), .busy(busy_d), .done(done_d)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [3:0] pat;

    initial begin
        {rst_a, rst_b, rst_c, rst_d} = 4'b1111;
        ifa.din = '0; ifa.dvalid = 1'b0;
        ifb.din = '0; ifb.dvalid = 1'b0;
        ifc.din = '0; ifc.dvalid = 1'b0;
        ifd.din = '0; ifd.dvalid = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_a_sout", sout_a, 1);
        check("rst_a_busy", busy_a, 0);
        check("rst_a_done", done_a, 0);
        check("rst_a_sel", sel_a, 0);
        check("rst_a_lanes", ln_a, 0);
        check("rst_a_dready", ifa.dready, 1);
        check("rst_b_sel", sel_b, 3);
        check("rst_b_sout", sout_b, 1);
        check("rst_d_sout", sout_d, 0);
        {rst_a, rst_b, rst_c, rst_d} = 4'b0000;
        @(negedge clk);

        // Idle line with IDLE_LVL=0, no traffic for 20 cycles
        for (int k = 0; k < 20; k++) begin
            check("idle_d_sout", sout_d, 0);
            check("idle_d_busy", busy_d, 0);
            check("idle_d_done", done_d, 0);
            check("idle_d_dready", ifd.dready, 1);
            @(negedge clk);
        end

        // DIV=1 LSB first, 4'b1010 -> 0,1,0,1 then idle
        pat = 4'b1010;
        ifa.din = pat; ifa.dvalid = 1'b1;
        check("t1_dready_idle", ifa.dready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ifa.dvalid = 1'b0;
            check("t1_sout", sout_a, pat[i]);
            check("t1_busy", busy_a, 1);
            check("t1_done", done_a, (i == 3) ? 1 : 0);
            check("t1_dready", ifa.dready, (i == 3) ? 1 : 0);
        end
        @(negedge clk);
        check("t1_sout_idle", sout_a, 1);
        check("t1_busy_idle", busy_a, 0);
        check("t1_done_idle", done_a, 0);

        // dvalid with 4'h5 mid-transfer must be ignored
        pat = 4'b1100;
        ifa.din = pat; ifa.dvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ifa.dvalid = 1'b0;
            check("t4_sout", sout_a, pat[i]);
            check("t4_lanes", ln_a, pat);
            if (i == 1) begin
                ifa.din = 4'h5; ifa.dvalid = 1'b1;
            end
        end
        repeat (2) begin
            @(negedge clk);
            check("t4_sout_idle", sout_a, 1);
            check("t4_busy_idle", busy_a, 0);
            check("t4_lanes_idle", ln_a, 4'b1100);
        end

        // Back-to-back 4'hF then 4'h0 with dvalid held high
        ifa.din = 4'hF; ifa.dvalid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("t3_sout", sout_a, (k <= 4) ? 1 : 0);
            check("t3_busy", busy_a, 1);
            check("t3_dready", ifa.dready, (k == 4 || k == 8) ? 1 : 0);
            check("t3_done", done_a, (k == 4 || k == 8) ? 1 : 0);
            if (k == 4) ifa.din = 4'h0;
            if (k == 8) ifa.dvalid = 1'b0;
        end
        @(negedge clk);
        check("t3_sout_idle", sout_a, 1);
        check("t3_busy_idle", busy_a, 0);

        // DIV=3 MSB first, 4'b0011 -> six 0s then six 1s
        ifb.din = 4'b0011; ifb.dvalid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            ifb.dvalid = 1'b0;
            check("t2_sout", sout_b, (k >= 6) ? 1 : 0);
            check("t2_sel", sel_b, 3 - k / 3);
            check("t2_done", done_b, (k == 11) ? 1 : 0);
            check("t2_dready", ifb.dready, (k == 11) ? 1 : 0);
        end
        @(negedge clk);
        check("t2_sout_idle", sout_b, 1);
        check("t2_busy_idle", busy_b, 0);
        check("t2_sel_idle", sel_b, 3);

        // DIV=2, reset during second bit of 4'b0110, then send 4'h9
        pat = 4'b0110;
        ifc.din = pat; ifc.dvalid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            ifc.dvalid = 1'b0;
            check("t5_sout", sout_c, pat[(k - 1) / 2]);
            check("t5_done", done_c, 0);
            if (k == 3) rst_c = 1'b1;
        end
        @(negedge clk);
        check("t5_rst_sout", sout_c, 1);
        check("t5_rst_busy", busy_c, 0);
        check("t5_rst_sel", sel_c, 0);
        check("t5_rst_lanes", ln_c, 0);
        check("t5_rst_done", done_c, 0);
        check("t5_rst_dready", ifc.dready, 1);
        rst_c = 1'b0;
        pat = 4'h9;
        ifc.din = pat; ifc.dvalid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            ifc.dvalid = 1'b0;
            check("t5_tx_sout", sout_c, pat[k / 2]);
            check("t5_tx_sel", sel_c, k / 2);
            check("t5_tx_done", done_c, (k == 7) ? 1 : 0);
        end
        @(negedge clk);
        check("t5_tx_sout_idle", sout_c, 1);
        check("t5_tx_busy_idle", busy_c, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
